// File: rtl/seg_scroll_if.sv
// Message-write and scroll-control bundle between a host and seg_scroll_buf.
// There is no valid/ready back-pressure: wr_en writes on every edge where it is high, and start/stop are single-cycle command pulses the buffer always accepts.
interface seg_scroll_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic [AW:0]   len;
  logic          start;
  logic          stop;
  logic          busy;
  logic          wrap;
  logic [15:0]   dataBus;
  logic          dbg_state;

  modport master (
    output wr_en, wr_addr, wr_data, len, start, stop,
    input  busy, wrap, dataBus, dbg_state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, len, start, stop,
    output busy, wrap, dataBus, dbg_state
  );
endinterface

// File: rtl/seg_scroll_buf.sv
// Glyph message buffer with a registered 4-glyph sliding window for the 7-seg scan driver.
// Define SEG_SCROLL_BOUNCE_EN for ping-pong scrolling instead of circular wrap.
module seg_scroll_buf #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int STEP_DIV = 95
) (
  input logic         clk190Hz,
  input logic         rst,
  seg_scroll_if.slave bus
);
  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(STEP_DIV - 1);
  localparam logic [AW:0]   LEN_MAX   = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SCROLL} state_t;

  state_t        state;
  logic [3:0]    msg [DEPTH];
  logic [AW-1:0] ofs;
  logic [AW:0]   len_q;
  logic [TW-1:0] tick;
  logic          busy_q;
  logic          wrap_q;
  logic [15:0]   data_q;
  logic [AW:0]   len_clamp;
  logic [15:0]   window;
  logic [AW+1:0] idx;
`ifdef SEG_SCROLL_BOUNCE_EN
  logic          dir;
`endif

  always_ff @(posedge clk190Hz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) msg[i] <= 4'hF;
    end else if (bus.wr_en) begin
      msg[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    len_clamp = bus.len;
    if (bus.len == '0)          len_clamp = (AW+1)'(1);
    else if (bus.len > LEN_MAX) len_clamp = LEN_MAX;
  end

  // ofs < len_q, so three conditional subtractions cover ofs+3 even for len_q of 1..3.
  always_comb begin
    window = '0;
    idx    = '0;
    for (int k = 0; k < 4; k++) begin
      idx = {2'b00, ofs} + (AW+2)'(k);
      for (int r = 0; r < 3; r++) begin
        if (idx >= {1'b0, len_q}) idx = idx - {1'b0, len_q};
      end
      window[15-4*k -: 4] = msg[idx[AW-1:0]];
    end
  end

  always_ff @(posedge clk190Hz or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ofs    <= '0;
      len_q  <= LEN_MAX;
      tick   <= '0;
      busy_q <= 1'b0;
      wrap_q <= 1'b0;
      data_q <= 16'hFFFF;
`ifdef SEG_SCROLL_BOUNCE_EN
      dir    <= 1'b0;
`endif
    end else begin
      data_q <= window;
      wrap_q <= 1'b0;
      case (state)
        IDLE: begin
          ofs  <= '0;
          tick <= '0;
          if (bus.start && !bus.stop) begin
            state  <= SCROLL;
            busy_q <= 1'b1;
            len_q  <= len_clamp;
`ifdef SEG_SCROLL_BOUNCE_EN
            dir    <= 1'b0;
`endif
          end
        end
        SCROLL: begin
          if (bus.stop) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            ofs    <= '0;
            tick   <= '0;
`ifdef SEG_SCROLL_BOUNCE_EN
            dir    <= 1'b0;
`endif
          end else if (bus.start) begin
            ofs   <= '0;
            tick  <= '0;
            len_q <= len_clamp;
`ifdef SEG_SCROLL_BOUNCE_EN
            dir   <= 1'b0;
`endif
          end else if (tick == TICK_LAST) begin
            tick <= '0;
`ifdef SEG_SCROLL_BOUNCE_EN
            // Window never runs past the last glyph, so messages of 4 or fewer stay put.
            if (len_q > (AW+1)'(4)) begin
              if (!dir) begin
                if ({1'b0, ofs} == len_q - (AW+1)'(4)) begin
                  ofs    <= ofs - 1'b1;
                  dir    <= 1'b1;
                  wrap_q <= 1'b1;
                end else begin
                  ofs <= ofs + 1'b1;
                end
              end else begin
                if (ofs == '0) begin
                  ofs    <= ofs + 1'b1;
                  dir    <= 1'b0;
                  wrap_q <= 1'b1;
                end else begin
                  ofs <= ofs - 1'b1;
                end
              end
            end
`else
            if ({1'b0, ofs} == len_q - (AW+1)'(1)) begin
              ofs    <= '0;
              wrap_q <= 1'b1;
            end else begin
              ofs <= ofs + 1'b1;
            end
`endif
          end else begin
            tick <= tick + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.wrap      = wrap_q;
  assign bus.dataBus   = data_q;
  assign bus.dbg_state = (state == SCROLL);
endmodule

// File: tb/tb_seg_scroll_buf.sv
// Directed bench for seg_scroll_buf with STEP_DIV=4; expectations follow SEG_SCROLL_BOUNCE_EN when defined.
module tb_seg_scroll_buf;
  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int STEP_DIV = 4;

`ifdef SEG_SCROLL_BOUNCE_EN
  localparam logic [15:0] EXP_LEN2_STEP1 = 16'hABAB;
  localparam logic        EXP_LEN1_WRAP  = 1'b0;
  localparam int          WRAP6_A        = 12;
  localparam int          WRAP6_B        = 20;
  localparam int          WRAP16_N       = 52;
`else
  localparam logic [15:0] EXP_LEN2_STEP1 = 16'hBABA;
  localparam logic        EXP_LEN1_WRAP  = 1'b1;
  localparam int          WRAP6_A        = 24;
  localparam int          WRAP6_B        = -1;
  localparam int          WRAP16_N       = 64;
`endif

  logic clk190Hz = 1'b0;
  logic rst      = 1'b1;
  int   n_cmp    = 0;
  int   n_err    = 0;
  logic [15:0] tab [7];

  always #5 clk190Hz = ~clk190Hz;

  seg_scroll_if #(.AW(AW)) bus ();

  seg_scroll_buf #(.DEPTH(DEPTH), .AW(AW), .STEP_DIV(STEP_DIV)) dut (
    .clk190Hz (clk190Hz),
    .rst      (rst),
    .bus      (bus.slave)
  );

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic next(input int n);
    repeat (n) @(negedge clk190Hz);
  endtask

  task automatic write_slot(input logic [AW-1:0] a, input logic [3:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    next(1);
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse(input logic s, input logic p, input logic [AW:0] l);
    bus.start = s;
    bus.stop  = p;
    bus.len   = l;
    next(1);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef SEG_SCROLL_BOUNCE_EN
    tab = '{16'h1234, 16'h2345, 16'h3456, 16'h2345, 16'h1234, 16'h2345, 16'h3456};
`else
    tab = '{16'h1234, 16'h2345, 16'h3456, 16'h4561, 16'h5612, 16'h6123, 16'h1234};
`endif
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.len = '0; bus.start = 1'b0; bus.stop = 1'b0;

    // reset state
    next(2);
    check16("reset_data", bus.dataBus, 16'hFFFF);
    check1("reset_busy", bus.busy, 1'b0);
    check1("reset_wrap", bus.wrap, 1'b0);
    rst = 1'b0;
    next(1);

    // idle window after loading 1..6
    for (int i = 0; i < 6; i++) write_slot(AW'(i), 4'(i + 1));
    next(1);
    check16("idle_window", bus.dataBus, 16'h1234);
    check1("idle_busy", bus.busy, 1'b0);

    // scroll with len=6
    pulse(1'b1, 1'b0, 5'd6);
    check1("scroll_busy", bus.busy, 1'b1);
    check16("scroll_n0", bus.dataBus, 16'h1234);
    check1("scroll_wrap_n0", bus.wrap, 1'b0);
    for (int n = 1; n <= 25; n++) begin
      next(1);
      check1($sformatf("scroll_wrap_n%0d", n), bus.wrap, (n == WRAP6_A) || (n == WRAP6_B));
      if (n % 4 == 1) check16($sformatf("scroll_data_n%0d", n), bus.dataBus, tab[(n - 1) / 4]);
    end

    // start and stop together while busy: stop wins
    pulse(1'b1, 1'b1, 5'd6);
    check1("startstop_busy", bus.busy, 1'b0);
    check1("startstop_wrap", bus.wrap, 1'b0);
    next(1);
    check16("startstop_data", bus.dataBus, 16'h1234);
    check1("startstop_busy2", bus.busy, 1'b0);

    // write during scroll, then restart mid-scroll
    pulse(1'b1, 1'b0, 5'd6);
    write_slot(4'd1, 4'h9);
    check16("wr_latency_old", bus.dataBus, 16'h1234);
    next(1);
    check16("wr_visible", bus.dataBus, 16'h1934);
    check1("wr_busy", bus.busy, 1'b1);
    next(3);
    check16("wr_step1", bus.dataBus, 16'h9345);
    pulse(1'b1, 1'b0, 5'd6);
    next(1);
    check16("restart_ofs0", bus.dataBus, 16'h1934);
    check1("restart_busy", bus.busy, 1'b1);
    pulse(1'b0, 1'b1, 5'd6);
    check1("stop_busy", bus.busy, 1'b0);

    // short messages and length clamping
    write_slot(4'd0, 4'hA);
    write_slot(4'd1, 4'hB);
    pulse(1'b1, 1'b0, 5'd2);
    next(1);
    check16("len2_data", bus.dataBus, 16'hABAB);
    next(4);
    check16("len2_step1", bus.dataBus, EXP_LEN2_STEP1);
    pulse(1'b0, 1'b1, 5'd0);

    pulse(1'b1, 1'b0, 5'd0);
    next(1);
    check16("len0_data", bus.dataBus, 16'hAAAA);
    next(2);
    check1("len0_wrap_n3", bus.wrap, 1'b0);
    next(1);
    check1("len0_wrap_n4", bus.wrap, EXP_LEN1_WRAP);
    pulse(1'b0, 1'b1, 5'd0);

    pulse(1'b1, 1'b0, 5'd31);
    next(1);
    check16("len31_data", bus.dataBus, 16'hAB34);
    for (int n = 2; n <= 64; n++) begin
      next(1);
      if (n == 49) check16("len31_ofs12", bus.dataBus, 16'hFFFF);
      if (n == WRAP16_N - 1) check1("len31_prewrap", bus.wrap, 1'b0);
      if (n == WRAP16_N) check1("len31_wrap", bus.wrap, 1'b1);
    end

    // asynchronous reset mid-scroll
    check1("pre_rst_busy", bus.busy, 1'b1);
    rst = 1'b1;
    #1;
    check16("rst_async_data", bus.dataBus, 16'hFFFF);
    check1("rst_async_busy", bus.busy, 1'b0);
    check1("rst_async_wrap", bus.wrap, 1'b0);
    next(1);
    check16("rst_hold_data", bus.dataBus, 16'hFFFF);
    rst = 1'b0;
    next(1);
    check16("rst_buf_cleared", bus.dataBus, 16'hFFFF);
    check1("rst_state_idle", bus.dbg_state, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
